// File: rtl/dma_pkg.sv
// Shared definitions for the DDR application-interface responder.
// Provides the command encodings, data width and address width used by
// every block that talks to the memory-controller style app interface.
package dma_pkg;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 27;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Both FIFOs in the responder are four entries deep; counts run 0..4.
  localparam int          FIFO_DEPTH = 4;
  localparam logic [2:0]  FIFO_FULL  = 3'd4;

  function automatic logic is_known_cmd(input logic [2:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/sfifo.sv
// Four-entry synchronous FIFO with a width parameter.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_data when not full (or when popping while full)
//   pop        : drop the head entry when not empty
//   head       : current head entry (valid while count != 0)
//   count      : number of stored entries, 0..4
module sfifo
  import dma_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [2:0]   count
);

  logic [W-1:0] store [FIFO_DEPTH];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 3'd0);
  assign do_push = push && ((count != FIFO_FULL) || do_pop);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ddr_app_responder.sv
// Behavioural responder for a DDR memory-controller application interface.
// Holds 2^DEPTH_LOG2 words of 256 bits, pairs write commands with write data
// beats in FIFO order, and returns read data a fixed RD_LAT cycles later.
//
// Ports:
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   app_addr/app_cmd/app_en: command channel, app_rdy accepts it
//   app_wdf_*              : write-data channel, app_wdf_rdy accepts a beat
//   app_rd_data*           : read return, one valid+end pulse per read
//   o_proto_err            : sticky protocol-violation flag
//
// Handshake: a command transfers in a cycle where app_en && app_rdy; a data
// beat transfers in a cycle where app_wdf_wren && app_wdf_rdy. Ready never
// depends on the matching valid, so the master may present and hold a
// request freely; nothing transfers while ready is low.
module ddr_app_responder
  import dma_pkg::*;
#(
  parameter int DEPTH_LOG2   = 6,
  parameter int ADDR_LSB     = 3,
  parameter int RD_LAT       = 8,
  parameter int STALL_PERIOD = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] app_addr,
  input  logic [2:0]        app_cmd,
  input  logic              app_en,
  output logic              app_rdy,
  input  logic              app_wdf_wren,
  input  logic              app_wdf_end,
  input  logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_rdy,
  output logic [DATA_W-1:0] app_rd_data,
  output logic              app_rd_data_valid,
  output logic              app_rd_data_end,
  output logic              o_proto_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  stall_now;
  logic                  is_wr;
  logic                  is_rd;
  logic                  cmd_acc;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  bad_cmd;
  logic                  beat_acc;
  logic                  beat_drop;
  logic                  pair;
  logic [2:0]            wcmd_cnt;
  logic [2:0]            wdf_cnt;
  logic [DEPTH_LOG2-1:0] wcmd_head;
  logic [DATA_W-1:0]     wdf_head;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [RD_LAT-1:0]     v_pipe;
  logic [DATA_W-1:0]     d_pipe [RD_LAT];
  logic                  unused_addr;

  // Only the index field selects a word; other address bits wrap.
  assign word_idx    = app_addr[ADDR_LSB +: DEPTH_LOG2];
  assign unused_addr = ^app_addr;

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      logic [SW-1:0] stall_cnt;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                stall_cnt <= '0;
        else if (stall_cnt == SW'(STALL_PERIOD-1)) stall_cnt <= '0;
        else                                      stall_cnt <= stall_cnt + SW'(1);
      end

      assign stall_now = (stall_cnt == SW'(STALL_PERIOD-1));
    end else begin : g_no_stall
      assign stall_now = 1'b0;
    end
  endgenerate

  // Writes may queue up to four commands; anything else (reads and unknown
  // encodings) waits for the write queue to drain so reads see all writes.
  assign is_wr   = (app_cmd == CMD_WRITE);
  assign is_rd   = (app_cmd == CMD_READ);
  assign app_rdy = !stall_now && (is_wr ? (wcmd_cnt < FIFO_FULL) : (wcmd_cnt == 3'd0));
  assign cmd_acc = app_en && app_rdy;
  assign wr_acc  = cmd_acc && is_wr;
  assign rd_acc  = cmd_acc && is_rd;
  assign bad_cmd = cmd_acc && !is_known_cmd(app_cmd);

  assign app_wdf_rdy = (wdf_cnt < FIFO_FULL);
  assign beat_acc    = app_wdf_wren && app_wdf_rdy;
  assign beat_drop   = app_wdf_wren && !app_wdf_rdy;

  assign pair = (wcmd_cnt != 3'd0) && (wdf_cnt != 3'd0);

  sfifo #(.W(DEPTH_LOG2)) u_wcmd_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (wr_acc),
    .push_data (word_idx),
    .pop       (pair),
    .head      (wcmd_head),
    .count     (wcmd_cnt)
  );

  sfifo #(.W(DATA_W)) u_wdf_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (beat_acc),
    .push_data (app_wdf_data),
    .pop       (pair),
    .head      (wdf_head),
    .count     (wdf_cnt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (pair) begin
      mem[wcmd_head] <= wdf_head;
    end
  end

  // Read pipeline: valid shifts every cycle; data stages only advance behind
  // a valid, so the last stage holds the most recent read between pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) d_pipe[i] <= '0;
    end else begin
      v_pipe[0] <= rd_acc;
      if (rd_acc) d_pipe[0] <= mem[word_idx];
      for (int i = 1; i < RD_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        if (v_pipe[i-1]) d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  assign app_rd_data       = d_pipe[RD_LAT-1];
  assign app_rd_data_valid = v_pipe[RD_LAT-1];
  assign app_rd_data_end   = v_pipe[RD_LAT-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_proto_err <= 1'b0;
    end else if (bad_cmd || beat_drop || (beat_acc && !app_wdf_end)) begin
      o_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_app_responder.sv
// Directed bench for ddr_app_responder: one task per scenario, inline checks.
module tb_ddr_app_responder;
  import dma_pkg::*;

  localparam int RD_LAT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance (no stall) ----------------
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;
  logic              proto_err;

  ddr_app_responder #(.DEPTH_LOG2(6), .ADDR_LSB(3), .RD_LAT(RD_LAT), .STALL_PERIOD(0)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .app_addr          (app_addr),
    .app_cmd           (app_cmd),
    .app_en            (app_en),
    .app_rdy           (app_rdy),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data_end   (app_rd_data_end),
    .o_proto_err       (proto_err)
  );

  // ---------------- stall instance ----------------
  logic [ADDR_W-1:0] s_app_addr;
  logic [2:0]        s_app_cmd;
  logic              s_app_en;
  logic              s_app_rdy;
  logic              s_app_wdf_wren;
  logic              s_app_wdf_end;
  logic [DATA_W-1:0] s_app_wdf_data;
  logic              s_app_wdf_rdy;
  logic [DATA_W-1:0] s_app_rd_data;
  logic              s_app_rd_data_valid;
  logic              s_app_rd_data_end;
  logic              s_proto_err;

  ddr_app_responder #(.DEPTH_LOG2(6), .ADDR_LSB(3), .RD_LAT(RD_LAT), .STALL_PERIOD(4)) dut_stall (
    .i_clk             (clk),
    .i_rst             (rst),
    .app_addr          (s_app_addr),
    .app_cmd           (s_app_cmd),
    .app_en            (s_app_en),
    .app_rdy           (s_app_rdy),
    .app_wdf_wren      (s_app_wdf_wren),
    .app_wdf_end       (s_app_wdf_end),
    .app_wdf_data      (s_app_wdf_data),
    .app_wdf_rdy       (s_app_wdf_rdy),
    .app_rd_data       (s_app_rd_data),
    .app_rd_data_valid (s_app_rd_data_valid),
    .app_rd_data_end   (s_app_rd_data_end),
    .o_proto_err       (s_proto_err)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] a5_word;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [2:0] cmd, input logic [ADDR_W-1:0] addr,
                       input logic wren, input logic [DATA_W-1:0] data, input logic wend);
    @(negedge clk);
    app_en       = en;
    app_cmd      = cmd;
    app_addr     = addr;
    app_wdf_wren = wren;
    app_wdf_data = data;
    app_wdf_end  = wend;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, CMD_WRITE, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one read and watches the return for a bounded number of cycles.
  // lat is the cycle count from accept to the valid pulse (-1 when no pulse arrives);
  // width counts cycles with valid and end both high (mismatch adds 100).
  task automatic read_one(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data,
                          output int lat, output int width, output logic rdy_seen);
    @(negedge clk);
    app_en       = 1'b1;
    app_cmd      = CMD_READ;
    app_addr     = addr;
    app_wdf_wren = 1'b0;
    #1 rdy_seen  = app_rdy;
    @(posedge clk);
    lat   = -1;
    width = 0;
    data  = '0;
    for (int n = 1; n <= RD_LAT + 4; n++) begin
      @(negedge clk);
      if (n == 1) app_en = 1'b0;
      if (app_rd_data_valid && app_rd_data_end) begin
        width++;
        if (lat < 0) begin
          lat  = n;
          data = app_rd_data;
        end
      end else if (app_rd_data_valid || app_rd_data_end) begin
        width += 100;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    app_en = 1'b0; app_cmd = CMD_WRITE; app_addr = '0;
    app_wdf_wren = 1'b0; app_wdf_end = 1'b1; app_wdf_data = '0;
    s_app_en = 1'b0; s_app_cmd = CMD_READ; s_app_addr = '0;
    s_app_wdf_wren = 1'b0; s_app_wdf_end = 1'b1; s_app_wdf_data = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (app_rdy !== 1'b1) begin bad++; $display("FAIL reset_app_rdy: got %b want 1", app_rdy); end
    total++; if (app_wdf_rdy !== 1'b1) begin bad++; $display("FAIL reset_wdf_rdy: got %b want 1", app_wdf_rdy); end
    total++; if (app_rd_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", app_rd_data_valid); end
    total++; if (app_rd_data_end !== 1'b0) begin bad++; $display("FAIL reset_end: got %b want 0", app_rd_data_end); end
    total++; if (app_rd_data !== '0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", app_rd_data); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] d;
    int lat, w;
    logic r;
    drive(1'b1, CMD_WRITE, 27'h000008, 1'b1, a5_word, 1'b1);
    idle(2);
    read_one(27'h000008, d, lat, w, r);
    total++; if (r !== 1'b1) begin bad++; $display("FAIL wr_rd_accept: got %b want 1", r); end
    total++; if (lat !== RD_LAT) begin bad++; $display("FAIL wr_rd_latency: got %0d want %0d", lat, RD_LAT); end
    total++; if (w !== 1) begin bad++; $display("FAIL wr_rd_pulse_width: got %0d want 1", w); end
    total++; if (d !== a5_word) begin bad++; $display("FAIL wr_rd_data: got %h want %h", d, a5_word); end
    total++; if (app_rd_data !== a5_word) begin bad++; $display("FAIL wr_rd_hold: got %h want %h", app_rd_data, a5_word); end
  endtask

  task automatic test_data_first();
    logic [DATA_W-1:0] d;
    int lat, w;
    logic r;
    for (int k = 1; k <= 3; k++) drive(1'b0, CMD_READ, '0, 1'b1, DATA_W'(k), 1'b1);
    drive(1'b1, CMD_WRITE, 27'h000010, 1'b0, '0, 1'b1);
    drive(1'b1, CMD_WRITE, 27'h000018, 1'b0, '0, 1'b1);
    drive(1'b1, CMD_WRITE, 27'h000020, 1'b0, '0, 1'b1);
    idle(2);
    for (int k = 1; k <= 3; k++) begin
      read_one(ADDR_W'(27'h000008 + 8 * k), d, lat, w, r);
      total++; if (d !== DATA_W'(k) || lat !== RD_LAT) begin
        bad++; $display("FAIL data_first_read%0d: got %h lat %0d want %h lat %0d", k, d, lat, DATA_W'(k), RD_LAT);
      end
    end
  endtask

  task automatic test_cmd_full();
    logic [DATA_W-1:0] d;
    int lat, w;
    logic r;
    for (int k = 0; k < 4; k++) drive(1'b1, CMD_WRITE, ADDR_W'(27'h000040 + 8 * k), 1'b0, '0, 1'b1);
    @(negedge clk);
    app_en = 1'b0; app_wdf_wren = 1'b0;
    app_cmd = CMD_WRITE;
    #1 total++; if (app_rdy !== 1'b0) begin bad++; $display("FAIL full_write_rdy: got %b want 0", app_rdy); end
    app_cmd = CMD_READ;
    #1 total++; if (app_rdy !== 1'b0) begin bad++; $display("FAIL full_read_rdy: got %b want 0", app_rdy); end
    app_cmd = 3'b010;
    #1 total++; if (app_rdy !== 1'b0) begin bad++; $display("FAIL full_other_rdy: got %b want 0", app_rdy); end
    @(posedge clk);
    drive(1'b0, CMD_WRITE, '0, 1'b1, 256'h77, 1'b1);
    @(negedge clk);
    app_wdf_wren = 1'b0; app_cmd = CMD_WRITE;
    #1 total++; if (app_rdy !== 1'b0) begin bad++; $display("FAIL beat_unpaired_rdy: got %b want 0", app_rdy); end
    @(posedge clk);
    @(negedge clk);
    #1 total++; if (app_rdy !== 1'b1) begin bad++; $display("FAIL beat_paired_rdy: got %b want 1", app_rdy); end
    drive(1'b0, CMD_WRITE, '0, 1'b1, 256'h88, 1'b1);
    drive(1'b0, CMD_WRITE, '0, 1'b1, 256'h99, 1'b1);
    drive(1'b0, CMD_WRITE, '0, 1'b1, 256'hAA, 1'b1);
    idle(2);
    read_one(27'h000040, d, lat, w, r);
    total++; if (d !== 256'h77) begin bad++; $display("FAIL full_read_0x40: got %h want 77", d); end
    read_one(27'h000058, d, lat, w, r);
    total++; if (d !== 256'hAA) begin bad++; $display("FAIL full_read_0x58: got %h want aa", d); end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    logic [DATA_W-1:0] exp_d;
    int nvalid = 0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back(a5_word);
    exp_q.push_back(256'd1);
    exp_q.push_back(256'd2);
    exp_q.push_back(256'd3);
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    for (int t = 0; t < RD_LAT + 10; t++) begin
      @(negedge clk);
      exp_v = (t >= RD_LAT) && (t < RD_LAT + 8);
      total++; if (app_rd_data_valid !== exp_v) begin bad++; $display("FAIL b2b_valid t=%0d: got %b want %b", t, app_rd_data_valid, exp_v); end
      if (app_rd_data_valid === 1'b1) begin
        nvalid++;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++; if (app_rd_data !== exp_d) begin bad++; $display("FAIL b2b_data t=%0d: got %h want %h", t, app_rd_data, exp_d); end
      end
      if (t < 8) begin
        app_en = 1'b1; app_cmd = CMD_READ; app_addr = ADDR_W'(8 * t);
        #1 total++; if (app_rdy !== 1'b1) begin bad++; $display("FAIL b2b_accept t=%0d: got %b want 1", t, app_rdy); end
      end else begin
        app_en = 1'b0;
      end
    end
    total++; if (nvalid !== 8 || exp_q.size() !== 0) begin bad++; $display("FAIL b2b_count: got %0d left %0d want 8 left 0", nvalid, exp_q.size()); end
  endtask

  task automatic test_stall();
    int accepts = 0;
    int lows = 0;
    int last_low = -1;
    int gap_bad = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      s_app_en = 1'b1; s_app_cmd = CMD_READ; s_app_addr = '0;
      #1;
      if (s_app_rdy === 1'b1) accepts++;
      else begin
        lows++;
        if (last_low >= 0 && t - last_low != 4) gap_bad++;
        last_low = t;
      end
    end
    @(negedge clk);
    s_app_en = 1'b0;
    total++; if (accepts !== 9) begin bad++; $display("FAIL stall_accepts: got %0d want 9", accepts); end
    total++; if (lows !== 3 || gap_bad !== 0) begin bad++; $display("FAIL stall_pattern: got %0d lows %0d bad gaps want 3 lows 0 bad gaps", lows, gap_bad); end
  endtask

  task automatic test_proto_err();
    logic [DATA_W-1:0] d;
    int lat, w;
    logic r;
    @(negedge clk);
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_before: got %b want 0", proto_err); end
    drive(1'b1, 3'b010, 27'h000008, 1'b0, '0, 1'b1);
    idle(1);
    @(negedge clk);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_set: got %b want 1", proto_err); end
    idle(5);
    read_one(27'h000008, d, lat, w, r);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_sticky: got %b want 1", proto_err); end
    total++; if (d !== a5_word) begin bad++; $display("FAIL proto_cmd_ignored: got %h want %h", d, a5_word); end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d;
    int lat, w;
    logic r;
    int late_valid = 0;
    @(negedge clk);
    app_en = 1'b1; app_cmd = CMD_READ; app_addr = 27'h000010;
    @(posedge clk);
    @(negedge clk);
    app_en = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL midrst_proto: got %b want 0", proto_err); end
    rst = 1'b0;
    app_cmd = CMD_WRITE;
    #1 total++; if (app_rdy !== 1'b1 || app_wdf_rdy !== 1'b1) begin
      bad++; $display("FAIL midrst_ready: got rdy %b wdf %b want 1 1", app_rdy, app_wdf_rdy);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (app_rd_data_valid !== 1'b0) late_valid++;
    end
    total++; if (late_valid !== 0) begin bad++; $display("FAIL midrst_no_valid: got %0d want 0", late_valid); end
    read_one(27'h000010, d, lat, w, r);
    total++; if (d !== '0 || lat !== RD_LAT) begin bad++; $display("FAIL midrst_mem_0x10: got %h lat %0d want 0 lat %0d", d, lat, RD_LAT); end
    read_one(27'h000008, d, lat, w, r);
    total++; if (d !== '0) begin bad++; $display("FAIL midrst_mem_0x08: got %h want 0", d); end
  endtask

  task automatic test_wdf_full();
    for (int k = 0; k < 4; k++) drive(1'b0, CMD_WRITE, '0, 1'b1, DATA_W'(k), 1'b1);
    @(negedge clk);
    app_wdf_wren = 1'b0;
    total++; if (app_wdf_rdy !== 1'b0 || proto_err !== 1'b0) begin
      bad++; $display("FAIL wdf_full: got rdy %b err %b want 0 0", app_wdf_rdy, proto_err);
    end
    drive(1'b0, CMD_WRITE, '0, 1'b1, 256'h5, 1'b1);
    idle(1);
    @(negedge clk);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL wdf_drop_err: got %b want 1", proto_err); end
    pulse_reset();
    drive(1'b0, CMD_WRITE, '0, 1'b1, 256'h55, 1'b0);
    idle(1);
    @(negedge clk);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL beat_no_end_err: got %b want 1", proto_err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    a5_word = {32{8'hA5}};
    test_reset();
    test_write_read();
    test_data_first();
    test_cmd_full();
    test_back_to_back();
    test_stall();
    test_proto_err();
    test_reset_mid();
    test_wdf_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_app_responder.md
DDR_APP_RESPONDER -- requirements
Module: ddr_app_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, meaning memory holds 2^DEPTH_LOG2 words of 256 bits.
REQ-002 SHALL have parameter ADDR_LSB, default 3, meaning word index = app_addr[ADDR_LSB+DEPTH_LOG2-1:ADDR_LSB].
REQ-003 SHALL have parameter RD_LAT, default 8, meaning cycles from read accept to app_rd_data_valid (range 1..32).
REQ-004 SHALL have parameter STALL_PERIOD, default 0, meaning forced app_rdy-low interval (0 = disabled).
REQ-005 SHALL have i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have i_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have app_addr  in  27  command address.
REQ-008 SHALL have app_cmd  in  3  command; 3'b000 write, 3'b001 read.
REQ-009 SHALL have app_en  in  1  command valid.
REQ-010 SHALL have app_rdy  out  1  command accept.
REQ-011 SHALL have app_wdf_wren, app_wdf_end  in  1 each  write-data valid / last beat.
REQ-012 SHALL have app_wdf_data  in  256  write data.
REQ-013 SHALL have app_wdf_rdy  out  1  write-data accept.
REQ-014 SHALL have app_rd_data  out  256, app_rd_data_valid  out  1, app_rd_data_end  out  1  read return.
REQ-015 SHALL have o_proto_err  out  1  sticky protocol-violation flag.

Function
REQ-016 SHALL accept a command in any cycle with app_en && app_rdy, and a data beat with app_wdf_wren && app_wdf_rdy.
REQ-017 SHALL compute app_rdy combinationally as !stall_now && (app_cmd==write ? wcmd_cnt<4 : wcmd_cnt==0); other encodings use the read rule.
REQ-018 SHALL push accepted write commands (word index) into a 4-deep write-command FIFO and accepted data beats into a 4-deep write-data FIFO; app_wdf_rdy = wdf_cnt<4.
REQ-019 SHALL, in any cycle both FIFOs are non-empty, pop one entry from each and write the data to the memory word; the memory update is visible on the next cycle.
REQ-020 SHALL allow data to precede or follow its command by any number of beats; pairing is strictly FIFO order.
REQ-021 SHALL, on read accept, sample the addressed memory word in that cycle and launch it into an RD_LAT-stage valid/data shift pipeline; back-to-back reads are accepted every cycle.
REQ-022 SHALL drive app_rd_data_valid and app_rd_data_end high together for exactly one cycle per read, RD_LAT cycles after accept, in acceptance order; app_rd_data holds its last value when valid is low.
REQ-023 SHALL, because reads need wcmd_cnt==0, return data reflecting every previously accepted and paired write (read-after-write ordering).
REQ-024 SHALL, when STALL_PERIOD>0, run a free-running counter modulo STALL_PERIOD and assert stall_now when it equals STALL_PERIOD-1.
REQ-025 SHALL accept and otherwise ignore any app_cmd other than 000/001, setting o_proto_err.
REQ-026 SHALL set o_proto_err on an accepted data beat with app_wdf_end==0, and on app_wdf_wren while app_wdf_rdy==0 (beat dropped).
REQ-027 SHALL ignore app_addr bits outside the index field (wrap-around on the memory depth).

Reset
REQ-028 SHALL, on i_rst, asynchronously clear both FIFOs, the read pipeline, the stall counter, o_proto_err, app_rd_data, app_rd_data_valid, app_rd_data_end, and every memory word to zero.
REQ-029 SHALL discard in-flight reads and unpaired writes on reset mid-operation; after release app_rdy=1 (STALL_PERIOD=0) and app_wdf_rdy=1.

Structure
REQ-030 SHALL take command encodings, 256-bit data width and 27-bit address width from shared package dma_pkg.
REQ-031 SHALL instantiate sub-module sfifo (4-deep synchronous FIFO, width parameter) twice: write-command and write-data.

Verification
REQ-032 Write addr 0x000008, data 0xA5 repeated, data with command -> read addr 0x000008 returns 0xA5... exactly RD_LAT=8 cycles after accept, valid and end high one cycle.
REQ-033 Send 3 data beats (1,2,3), then 3 writes to 0x10,0x18,0x20 -> reads of those addresses return 1,2,3 in order.
REQ-034 4 write commands with no data -> app_rdy low for a further write and for any read; supplying 1 beat -> write app_rdy high again.
REQ-035 8 back-to-back reads of addresses 0..0x38 -> 8 consecutive valid cycles, data in order, never-written words return 0.
REQ-036 STALL_PERIOD=4, app_en held with reads -> app_rdy low every 4th cycle, exactly 3 accepts per 4 cycles; app_cmd=3'b010 -> o_proto_err=1 until reset.
REQ-037 Assert i_rst 3 cycles after a read accept -> no app_rd_data_valid afterward, memory reads 0, o_proto_err=0.
